// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU M-stage back end: Funct3 encodings and
// the divider FSM state type.
package mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } divstate_t;

endpackage

// File: rtl/mdu_result_if.sv
// Operand, op-type, product and result signals exchanged between the
// pipeline (master) and the MDU back end (slave).
interface mdu_result_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0]   ForwardedSrcAE;
    logic [XLEN-1:0]   ForwardedSrcBE;
    logic              IntDivE;
    logic [2:0]        Funct3E;
    logic              W64E;
    logic [2:0]        Funct3M;
    logic              W64M;
    logic [2*XLEN-1:0] ProdM;
    logic              DivBusyE;
    logic [XLEN-1:0]   MDUResultW;

    modport master (
        output ForwardedSrcAE, ForwardedSrcBE, IntDivE, Funct3E, W64E,
        output Funct3M, W64M, ProdM,
        input  DivBusyE, MDUResultW
    );

    modport slave (
        input  ForwardedSrcAE, ForwardedSrcBE, IntDivE, Funct3E, W64E,
        input  Funct3M, W64M, ProdM,
        output DivBusyE, MDUResultW
    );
endinterface

// File: rtl/flopenrc.sv
// Pipeline register with synchronous reset, synchronous clear and enable.
// Clear takes priority over enable.
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)      q <= '0;
        else if (clear) q <= '0;
        else if (en)    q <= d;
    end
endmodule

// File: rtl/mdu_result_div_iter.sv
// Iterative radix-2 restoring divider with sign fix-up and M-stage quotient/
// remainder registers. MDU_DIV_FASTZERO_EN: divide-by-zero skips iteration.
import mdu_pkg::*;

module div_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            StallM,
    input  logic            FlushM,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    input  logic            IntDivE,
    input  logic            DivUnsignedE,
    input  logic            W64E,
    output logic            DivBusyE,
    output logic [XLEN-1:0] QuotM,
    output logic [XLEN-1:0] RemM
);
    localparam int CW = $clog2(XLEN) + 1;

    divstate_t       state;
    logic [XLEN-1:0] rem, quot, divisor;
    logic [CW-1:0]   count;
    logic            qneg, rneg;

    logic            wop, sgn, a_neg, b_neg, div_zero, launch;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_init;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] quot_fix, rem_fix;

    assign wop = W64E & (XLEN == 64);
    assign sgn = ~DivUnsignedE;

    always_comb begin
        a_ext = ForwardedSrcAE;
        b_ext = ForwardedSrcBE;
        if (wop) begin
            a_ext = sgn ? XLEN'($signed(ForwardedSrcAE[31:0])) : XLEN'(ForwardedSrcAE[31:0]);
            b_ext = sgn ? XLEN'($signed(ForwardedSrcBE[31:0])) : XLEN'(ForwardedSrcBE[31:0]);
        end
    end

    assign a_neg    = sgn & a_ext[XLEN-1];
    assign b_neg    = sgn & b_ext[XLEN-1];
    assign a_mag    = a_neg ? -a_ext : a_ext;
    assign b_mag    = b_neg ? -b_ext : b_ext;
    // W ops run 32 steps, so the dividend starts in the upper half of quot
    assign a_init   = wop ? (a_mag << 32) : a_mag;
    assign div_zero = (b_mag == '0);

    assign rem_sh = {rem, quot[XLEN-1]};
    assign diff   = rem_sh - {1'b0, divisor};

    // Busy is raised combinationally in the launch cycle so E stalls at once
    assign launch   = (state == IDLE) & IntDivE & ~FlushE;
    assign DivBusyE = launch | (state == BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            count   <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        divisor <= b_mag;
                        qneg    <= (a_neg ^ b_neg) & ~div_zero;
                        rneg    <= a_neg;
                        count   <= wop ? CW'(32) : CW'(XLEN);
`ifdef MDU_DIV_FASTZERO_EN
                        if (div_zero) begin
                            quot  <= '1;
                            rem   <= a_mag;
                            state <= DONE;
                        end else begin
                            quot  <= a_init;
                            rem   <= '0;
                            state <= BUSY;
                        end
`else
                        quot  <= a_init;
                        rem   <= '0;
                        state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    if (FlushE) begin
                        state <= IDLE;
                    end else begin
                        if (!diff[XLEN]) begin
                            rem  <= diff[XLEN-1:0];
                            quot <= {quot[XLEN-2:0], 1'b1};
                        end else begin
                            rem  <= rem_sh[XLEN-1:0];
                            quot <= {quot[XLEN-2:0], 1'b0};
                        end
                        count <= count - 1'b1;
                        if (count == CW'(1)) state <= DONE;
                    end
                end
                DONE: begin
                    if (FlushE | ~StallE) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign quot_fix = qneg ? -quot : quot;
    assign rem_fix  = rneg ? -rem  : rem;

    flopenrc #(.WIDTH(XLEN)) quot_reg (
        .clk(clk), .reset(reset), .clear(FlushM),
        .en((state == DONE) & ~StallM), .d(quot_fix), .q(QuotM)
    );

    flopenrc #(.WIDTH(XLEN)) rem_reg (
        .clk(clk), .reset(reset), .clear(FlushM),
        .en((state == DONE) & ~StallM), .d(rem_fix), .q(RemM)
    );
endmodule

// File: rtl/mdu_result.sv
// MDU M-stage back end: divider, result select with W-op sign extension,
// and the Writeback result register.
import mdu_pkg::*;

module mdu_result #(
    parameter int XLEN = 64
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  StallE,
    input  logic  FlushE,
    input  logic  StallM,
    input  logic  FlushM,
    input  logic  StallW,
    input  logic  FlushW,
    mdu_result_if.slave mdu
);
    logic [XLEN-1:0] QuotM, RemM, sel, result;
    logic            unused_f3e;

    assign unused_f3e = &{1'b0, mdu.Funct3E[2:1]};

    div_iter #(.XLEN(XLEN)) div (
        .clk(clk),
        .reset(reset),
        .StallE(StallE),
        .FlushE(FlushE),
        .StallM(StallM),
        .FlushM(FlushM),
        .ForwardedSrcAE(mdu.ForwardedSrcAE),
        .ForwardedSrcBE(mdu.ForwardedSrcBE),
        .IntDivE(mdu.IntDivE),
        .DivUnsignedE(mdu.Funct3E[0]),
        .W64E(mdu.W64E),
        .DivBusyE(mdu.DivBusyE),
        .QuotM(QuotM),
        .RemM(RemM)
    );

    always_comb begin
        sel = RemM;
        case (mdu.Funct3M)
            F3_MUL:                      sel = mdu.ProdM[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: sel = mdu.ProdM[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             sel = QuotM;
            default:                     sel = RemM;
        endcase
    end

    assign result = (mdu.W64M & (XLEN == 64)) ? XLEN'($signed(sel[31:0])) : sel;

    flopenrc #(.WIDTH(XLEN)) result_reg (
        .clk(clk), .reset(reset), .clear(FlushW),
        .en(~StallW), .d(result), .q(mdu.MDUResultW)
    );
endmodule
